// File: rtl/rep_burst_pkg.sv
// ---------------------------------------------------------------------------
// rep_burst_pkg
// Shared definitions for the repeated-burst generator:
//   - burst_state_t : FSM state encoding (IDLE, PULSE, GAP, TAIL)
//   - REP_N_DEF     : default number of pulses per burst
//   - GAP_W_DEF     : default width of the gap input
// ---------------------------------------------------------------------------
package rep_burst_pkg;

  localparam int REP_N_DEF = 3;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_TAIL  = 2'd3
  } burst_state_t;

endpackage

// File: rtl/rep_burst_gen_rise_det.sv
// ---------------------------------------------------------------------------
// rise_det
// Rising-edge detector: rise = d & ~d_q, where d_q is a registered copy of d.
// The registered copy resets to 0, so an input held high through reset
// produces one rise on the first clock after reset is released.
// Ports:
//   clk  : clock, posedge
//   rst  : synchronous active-high reset
//   d    : input to watch
//   rise : combinational rising-edge indication
// ---------------------------------------------------------------------------
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_dq;

  // Delayed copy of the input, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dq <= 1'b0;
    end else begin
      r_dq <= d;
    end
  end

  assign rise = d & ~r_dq;

endmodule

// File: rtl/rep_burst_gen.sv
// ---------------------------------------------------------------------------
// rep_burst_gen
// On a rising edge of a (sampled in IDLE) emits REP_N pulses on b separated
// by max(gap,1) low cycles; the last pulse lasts two cycles. done pulses for
// one cycle after the burst, ovr pulses for one cycle when a rise arrives
// while a burst is still running (that rise is dropped).
// Parameters:
//   REP_N : pulses per burst (1..15)
//   GAP_W : width of gap
// Ports:
//   clk  : clock, posedge
//   rst  : synchronous active-high reset
//   a    : trigger
//   gap  : b-low cycles between pulses, sampled with the trigger
//   b    : burst output (registered)
//   busy : burst in progress (registered)
//   done : one-cycle pulse after the burst (registered)
//   ovr  : one-cycle pulse for a dropped trigger (registered)
// Optional macro REP_BURST_GEN_ASSERT_EN compiles embedded concurrent
// assertions; behaviour is identical with or without it.
// ---------------------------------------------------------------------------
module rep_burst_gen
  import rep_burst_pkg::*;
#(
  parameter int REP_N = REP_N_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [GAP_W-1:0] gap,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             ovr
);

  // Pulse counter must reach REP_N without wrapping.
  localparam int PCNT_W = (REP_N < 2) ? 1 : $clog2(REP_N + 1);

  burst_state_t      r_state;
  logic [PCNT_W-1:0] r_pcnt;
  logic [GAP_W-1:0]  r_gcnt;
  logic [GAP_W-1:0]  r_gapQ;
  logic              r_b;
  logic              r_busy;
  logic              r_done;
  logic              r_ovr;
  logic              w_rise;

  rise_det u_rise_det (
    .clk  (clk),
    .rst  (rst),
    .d    (a),
    .rise (w_rise)
  );

  // Burst sequencer. Outputs are registered alongside the state so that b and
  // busy always match the state they describe. gap is latched only on the
  // accepted trigger (a zero gap becomes 1 so pulses never merge), which keeps
  // later changes on gap out of the running burst. Any rise seen outside IDLE
  // is dropped and flagged on ovr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pcnt  <= '0;
      r_gcnt  <= '0;
      r_gapQ  <= '0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovr  <= w_rise && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_PULSE;
            r_pcnt  <= PCNT_W'(1);
            r_gapQ  <= (gap == '0) ? GAP_W'(1) : gap;
            r_b     <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_pcnt == PCNT_W'(REP_N)) begin
            r_state <= ST_TAIL;
            r_b     <= 1'b1;
          end else begin
            r_state <= ST_GAP;
            r_gcnt  <= r_gapQ;
            r_b     <= 1'b0;
          end
        end
        ST_GAP: begin
          if (r_gcnt == GAP_W'(1)) begin
            r_state <= ST_PULSE;
            r_pcnt  <= r_pcnt + 1'b1;
            r_b     <= 1'b1;
          end else begin
            r_gcnt  <= r_gcnt - 1'b1;
          end
        end
        ST_TAIL: begin
          r_state <= ST_IDLE;
          r_b     <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_b     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign b    = r_b;
  assign busy = r_busy;
  assign done = r_done;
  assign ovr  = r_ovr;

`ifdef REP_BURST_GEN_ASSERT_EN
  // An accepted trigger is a rise seen while IDLE; dropped rises do not
  // start the burst-shape check.
  logic w_start;
  assign w_start = w_rise && (r_state == ST_IDLE);

  property p_burstShape;
    @(posedge clk) disable iff (rst) w_start |-> b[->REP_N] ##1 b;
  endproperty

  property p_firstPulse;
    @(posedge clk) disable iff (rst) w_start |=> b;
  endproperty

  property p_doneNotBusy;
    @(posedge clk) disable iff (rst) !(done && busy);
  endproperty

  a_burstShape:  assert property (p_burstShape);
  a_firstPulse:  assert property (p_firstPulse);
  a_doneNotBusy: assert property (p_doneNotBusy);
`endif

endmodule

// File: tb/tb_rep_burst_gen.sv
// ---------------------------------------------------------------------------
// tb_rep_burst_gen
// Drives two instances (REP_N=3 and REP_N=1) from shared inputs and compares
// every output each cycle with a timing model derived from the burst rules:
// for a burst accepted with latched gap g, outputs are a function of t, the
// number of clocks since the trigger edge.
// ---------------------------------------------------------------------------
module tb_rep_burst_gen;
  import rep_burst_pkg::*;

  localparam int GAP_W  = GAP_W_DEF;
  localparam int N_MAIN = REP_N_DEF;

  logic             clk = 1'b0;
  logic             rst;
  logic             a;
  logic [GAP_W-1:0] gap;
  logic             bMain, busyMain, doneMain, ovrMain;
  logic             bOne, busyOne, doneOne, ovrOne;

  rep_burst_gen #(.REP_N(N_MAIN), .GAP_W(GAP_W)) dutMain (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .gap  (gap),
    .b    (bMain),
    .busy (busyMain),
    .done (doneMain),
    .ovr  (ovrMain)
  );

  rep_burst_gen #(.REP_N(1), .GAP_W(GAP_W)) dutOne (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .gap  (gap),
    .b    (bOne),
    .busy (busyOne),
    .done (doneOne),
    .ovr  (ovrOne)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int repN [2] = '{N_MAIN, 1};
  bit mAq;
  bit act [2];
  int tCnt [2];
  int gLat [2];
  bit expB [2];
  bit expBusy [2];
  bit expDone [2];
  bit expOvr [2];

  // Offset of the last pulse's first cycle, counted from the trigger edge.
  function automatic int lastPulse(input int n, input int g);
    return 1 + (n - 1) * (g + 1);
  endfunction

  // b is high on every (g+1)-th cycle up to the last pulse, plus one extra
  // cycle that stretches the last pulse.
  function automatic bit pulseAt(input int t, input int n, input int g);
    int p;
    p = lastPulse(n, g);
    if (t >= 1 && t <= p && ((t - 1) % (g + 1)) == 0) return 1'b1;
    if (t == p + 1) return 1'b1;
    return 1'b0;
  endfunction

  // Advances the model by one clock edge using the inputs present at it.
  task automatic modelEdge();
    bit rise;
    bit busyNow;
    int p;
    if (rst) begin
      mAq = 1'b0;
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0; tCnt[i] = 0; gLat[i] = 1;
        expB[i] = 1'b0; expBusy[i] = 1'b0; expDone[i] = 1'b0; expOvr[i] = 1'b0;
      end
    end else begin
      rise = a && !mAq;
      mAq  = a;
      for (int i = 0; i < 2; i++) begin
        p = lastPulse(repN[i], gLat[i]);
        busyNow = act[i] && tCnt[i] >= 1 && tCnt[i] <= p + 1;
        expOvr[i] = rise && busyNow;
        if (act[i]) tCnt[i]++;
        if (rise && !busyNow) begin
          act[i]  = 1'b1;
          tCnt[i] = 1;
          gLat[i] = (gap == '0) ? 1 : int'(gap);
        end
        p = lastPulse(repN[i], gLat[i]);
        expB[i]    = act[i] && pulseAt(tCnt[i], repN[i], gLat[i]);
        expBusy[i] = act[i] && tCnt[i] <= p + 1;
        expDone[i] = act[i] && tCnt[i] == p + 2;
        if (act[i] && tCnt[i] >= p + 2) act[i] = 1'b0;
      end
    end
  endtask

  task automatic compareBit(input string tag, input logic obs, input bit exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    compareBit({step, " main.b"},    bMain,    expB[0]);
    compareBit({step, " main.busy"}, busyMain, expBusy[0]);
    compareBit({step, " main.done"}, doneMain, expDone[0]);
    compareBit({step, " main.ovr"},  ovrMain,  expOvr[0]);
    compareBit({step, " one.b"},     bOne,     expB[1]);
    compareBit({step, " one.busy"},  busyOne,  expBusy[1]);
    compareBit({step, " one.done"},  doneOne,  expDone[1]);
    compareBit({step, " one.ovr"},   ovrOne,   expOvr[1]);
  endtask

  // One clock: drive inputs at the falling edge, update the model at the
  // rising edge, then check the registered outputs at the next falling edge.
  task automatic applyStimulus(input string step, input logic rVal,
                               input logic aVal, input int gVal);
    rst = rVal;
    a   = aVal;
    gap = GAP_W'(gVal);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(step);
  endtask

  task automatic idleFor(input string step, input int n, input int gVal);
    for (int i = 0; i < n; i++) applyStimulus(step, 1'b0, 1'b0, gVal);
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; gap = '0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b1, 1'b0, 0);

    // Basic burst, gap=2
    applyStimulus("gap2", 1'b0, 1'b1, 2);
    idleFor("gap2", 11, 2);

    // gap=0 treated as 1
    applyStimulus("gap0", 1'b0, 1'b1, 0);
    idleFor("gap0", 9, 0);

    // Second rise during burst is dropped; gap change mid-burst ignored
    applyStimulus("ovr", 1'b0, 1'b1, 2);
    applyStimulus("ovr", 1'b0, 1'b0, 9);
    applyStimulus("ovr", 1'b0, 1'b0, 9);
    applyStimulus("ovr", 1'b0, 1'b1, 9);
    idleFor("ovr", 10, 7);

    // Reset mid-burst aborts without done, then a full burst follows
    applyStimulus("midrst", 1'b0, 1'b1, 2);
    idleFor("midrst", 4, 2);
    applyStimulus("midrst", 1'b1, 1'b0, 2);
    idleFor("midrst", 2, 2);
    applyStimulus("midrst", 1'b0, 1'b1, 2);
    idleFor("midrst", 11, 2);

    // a held high through reset gives one rise after release
    for (int i = 0; i < 3; i++) applyStimulus("holdrst", 1'b1, 1'b1, 1);
    for (int i = 0; i < 12; i++) applyStimulus("holdrst", 1'b0, 1'b1, 1);
    idleFor("holdrst", 2, 1);

    // Rise sampled in the done cycle is accepted
    applyStimulus("rediff", 1'b0, 1'b1, 0);
    idleFor("rediff", 6, 0);
    applyStimulus("rediff", 1'b0, 1'b1, 0);
    idleFor("rediff", 10, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic rVal, aVal;
      int gVal;
      rVal = ($urandom_range(0, 99) == 0);
      aVal = ($urandom_range(0, 3) == 0) ? ~a : a;
      gVal = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(0, 3));
      applyStimulus("random", rVal, aVal, gVal);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rep_burst_gen.md
REP_BURST_GEN -- requirements
Module: rep_burst_gen

Interface
REQ-001 Parameter REP_N, default 3: number of non-consecutive b pulses per burst, legal range 1..15.
REQ-002 Parameter GAP_W, default 4: width of the gap input.
REQ-003 Port clk  input  1  sole clock, all logic on posedge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port a  input  1  trigger; a burst starts on its sampled rising edge.
REQ-006 Port gap  input  GAP_W  number of b-low cycles between pulses, sampled on the trigger cycle.
REQ-007 Port b  output  1  generated burst, registered.
REQ-008 Port busy  output  1  high while a burst is in progress.
REQ-009 Port done  output  1  one-cycle pulse after the burst completes.
REQ-010 Port ovr  output  1  one-cycle pulse when a trigger is dropped.

Function
REQ-011 Rise detect SHALL be a & ~a_q, where a_q is a registered copy of a.
REQ-012 The FSM SHALL have exactly four states: IDLE, PULSE, GAP, TAIL.
REQ-013 Output b SHALL be 1 exactly when the state is PULSE or TAIL; busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 IDLE with rise sampled at posedge k SHALL move to PULSE, set pcnt=1, latch gap_q=max(gap,1), so b=1 in cycle k+1.
REQ-015 PULSE with pcnt==REP_N SHALL move to TAIL; otherwise it SHALL move to GAP and load gcnt=gap_q.
REQ-016 GAP with gcnt==1 SHALL move to PULSE and increment pcnt; otherwise it SHALL stay in GAP and decrement gcnt.
REQ-017 TAIL SHALL move to IDLE and set done=1 for exactly the following cycle.
REQ-018 The burst SHALL therefore satisfy rise(a) |-> b[->REP_N] ##1 b, with the final pulse lasting 2 cycles and all earlier pulses 1 cycle.
REQ-019 gap==0 SHALL be treated as 1, keeping pulses non-consecutive.
REQ-020 A rise sampled in any non-IDLE state, including TAIL, SHALL be ignored and SHALL produce ovr=1 for one cycle.
REQ-021 A rise sampled in IDLE while done=1 SHALL be accepted normally.
REQ-022 A change on gap during a burst SHALL have no effect on that burst.
REQ-023 Counters SHALL be sized to hold REP_N and 2^GAP_W-1 without wrap.

Reset
REQ-024 While rst=1 at a posedge, the next state SHALL be: state=IDLE, b=0, busy=0, done=0, ovr=0, a_q=0, pcnt=0, gcnt=0, gap_q=0.
REQ-025 Reset mid-burst SHALL abort the burst without asserting done.
REQ-026 If a is held high through reset, one rise SHALL be detected on the first posedge with rst=0.

Configuration
REQ-027 With REP_BURST_GEN_ASSERT_EN defined, the block SHALL contain embedded concurrent assertions: the REQ-018 goto property, one asserting that a rise in IDLE is followed by b=1 next cycle, and one asserting that done is never high together with busy; all are disabled iff rst.
REQ-028 Without REP_BURST_GEN_ASSERT_EN, no assertion code SHALL be compiled and the RTL behaviour SHALL be identical.

Structure
REQ-029 Package rep_burst_pkg SHALL hold the state enum type and the default constants REP_N_DEF=3 and GAP_W_DEF=4.
REQ-030 Rise detection SHALL be a sub-module, rise_det (ports clk, rst, d, rise), instantiated once.

Verification
REQ-031 REP_N=3, gap=2, a rises at posedge k -> b=1 at k+1, k+4, k+7, k+8; done=1 at k+9; busy=1 over k+1..k+8.
REQ-032 gap=0, REP_N=3 -> b pattern 1,0,1,0,1,1 starting k+1; done=1 at k+7.
REQ-033 Second rise of a at k+3 during the REQ-031 burst -> ovr=1 at k+4; burst unchanged; no second burst.
REQ-034 rst=1 at k+5 during the REQ-031 burst -> b=0, busy=0 from k+6; no done; a new rise afterwards gives a full burst.
REQ-035 REP_N=1 -> b=1 at k+1, k+2; done=1 at k+3; with the macro defined, no assertion failures in any scenario.
